// File: rtl/ads124x_spi_emu.sv
// ADS1248-style SPI slave emulator: register file over RREG/WREG, samples from AXI4-Stream
// served through RDATA/RDATAC, with DRDY generation.
module ads124x_spi_emu #(
   parameter int         NUM_REGS    = 15,
   parameter logic [3:0] ID_ADDR     = 4'hA,
   parameter logic [7:0] ID_VALUE    = 8'h90,
   parameter int         DRDY_HI_CYC = 4
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic [31:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        SCK,
   input  logic        SS,
   input  logic        DIN,
   output logic        DOUT,
   output logic        DOUT_T,
   input  logic        START,
   input  logic        RESET,
   output logic        DRDY,
   output logic        rdatac,
   output logic        frame_err
);

   typedef enum logic [2:0] {
      S_CMD, S_ARG_R, S_ARG_W, S_RD_REG, S_WR_REG, S_DATA
   } state_t;

   localparam logic [4:0] NUM_REGS_L = 5'(NUM_REGS);
   localparam logic [3:0] HI_CYC     = 4'(DRDY_HI_CYC);

   // ---------------------------------------------------------------- pin synchronizers
   logic [2:0] sck_q;
   logic [1:0] ss_q, din_q, rst_q;

   // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge aclk) begin
      if (areset) begin
         sck_q <= '0;
         ss_q  <= 2'b11;
         din_q <= '0;
         rst_q <= 2'b11;
      end else begin
         sck_q <= {sck_q[1:0], SCK};
         ss_q  <= {ss_q[0], SS};
         din_q <= {din_q[0], DIN};
         rst_q <= {rst_q[0], RESET};
      end
   end

   logic ss_s, din_s, dev_rst, sck_rise, sck_fall;
   assign ss_s     = ss_q[1];
   assign din_s    = din_q[1];
   assign dev_rst  = ~rst_q[1];
   assign sck_rise = ~ss_s &  sck_q[1] & ~sck_q[2];
   assign sck_fall = ~ss_s & ~sck_q[1] &  sck_q[2];

   // ---------------------------------------------------------------- datapath state
   state_t      state, state_nxt;
   logic [3:0]  ptr, ptr_nxt, cnt, cnt_nxt;
   logic [2:0]  bit_cnt;
   logic [6:0]  in_sr;
   logic [23:0] out_shift;
   logic [4:0]  rd_cnt;
   logic [23:0] held;
   logic [3:0]  hi_cnt, hi_nxt;
   logic        drdy_nxt;
   logic [7:0]  regs [NUM_REGS];
   logic [7:0]  rd_byte, rx_byte;
   logic        byte_done, data_done, sample_acc, rd_busy, drdy_fall;
   logic        cmd_rst, load_rd, load_data, set_rdatac, clr_rdatac, wr_en, wr_ok;

   assign rx_byte    = {in_sr, din_s};
   assign byte_done  = sck_fall & (bit_cnt == 3'd7);
   assign data_done  = sck_fall & (rd_cnt == 5'd1);
   assign sample_acc = s_axis_tvalid & s_axis_tready & START;
   // An armed RDATAC preload only counts as in progress once its frame has opened.
   assign rd_busy    = (rd_cnt != 5'd0) && ((rd_cnt != 5'd24) || !ss_s);
   assign wr_ok      = wr_en && (ptr != ID_ADDR) && ({1'b0, ptr} < NUM_REGS_L);

   // ---------------------------------------------------------------- command FSM
   always_ff @(posedge aclk) begin
      if (areset) begin
         state <= S_CMD;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt  = state;
      ptr_nxt    = ptr;
      cnt_nxt    = cnt;
      cmd_rst    = 1'b0;
      load_rd    = 1'b0;
      load_data  = 1'b0;
      set_rdatac = 1'b0;
      clr_rdatac = 1'b0;
      wr_en      = 1'b0;
      if (ss_s || dev_rst) begin
         state_nxt = S_CMD;
      end else begin
         case (state)
            S_CMD: if (byte_done) begin
               case (rx_byte[7:1])
                  7'h03:   cmd_rst    = 1'b1;
                  7'h09:   begin load_data = 1'b1; state_nxt = S_DATA; end
                  7'h0A:   set_rdatac = 1'b1;
                  7'h0B:   clr_rdatac = 1'b1;
                  default: begin
                     if (!rdatac && rx_byte[7:4] == 4'h2) begin
                        ptr_nxt = rx_byte[3:0]; state_nxt = S_ARG_R;
                     end else if (!rdatac && rx_byte[7:4] == 4'h4) begin
                        ptr_nxt = rx_byte[3:0]; state_nxt = S_ARG_W;
                     end
                  end
               endcase
            end
            S_ARG_R: if (byte_done) begin
               cnt_nxt = rx_byte[3:0]; load_rd = 1'b1; state_nxt = S_RD_REG;
            end
            S_ARG_W: if (byte_done) begin
               cnt_nxt = rx_byte[3:0]; state_nxt = S_WR_REG;
            end
            S_RD_REG: if (byte_done) begin
               if (cnt == 4'd0) state_nxt = S_CMD;
               else begin
                  ptr_nxt = ptr + 4'd1; cnt_nxt = cnt - 4'd1; load_rd = 1'b1;
               end
            end
            S_WR_REG: if (byte_done) begin
               wr_en = 1'b1;
               if (cnt == 4'd0) state_nxt = S_CMD;
               else begin
                  ptr_nxt = ptr + 4'd1; cnt_nxt = cnt - 4'd1;
               end
            end
            S_DATA: if (data_done) state_nxt = S_CMD;
            default: state_nxt = S_CMD;
         endcase
      end
   end

   always_comb begin
      rd_byte = 8'h00;
      if (ptr_nxt == ID_ADDR) rd_byte = ID_VALUE;
      else if ({1'b0, ptr_nxt} < NUM_REGS_L) rd_byte = regs[ptr_nxt];
   end

   // A sample landing with the 24th fall wins and forces the high pulse.
   always_comb begin
      drdy_nxt = DRDY;
      hi_nxt   = hi_cnt;
      if (hi_cnt != 4'd0) begin
         hi_nxt = hi_cnt - 4'd1;
         if (hi_cnt == 4'd1) drdy_nxt = 1'b0;
      end
      if (sample_acc) begin
         if (DRDY && hi_cnt == 4'd0 && !data_done) drdy_nxt = 1'b0;
         else begin
            drdy_nxt = 1'b1;
            hi_nxt   = HI_CYC;
         end
      end else if (data_done) begin
         drdy_nxt = 1'b1;
         hi_nxt   = 4'd0;
      end
   end
   assign drdy_fall = DRDY & ~drdy_nxt;

   // ---------------------------------------------------------------- shift, register file, DRDY
   always_ff @(posedge aclk) begin
      frame_err <= 1'b0;
      if (areset || dev_rst) begin
         s_axis_tready <= ~areset;
         bit_cnt   <= '0;
         in_sr     <= '0;
         out_shift <= '0;
         rd_cnt    <= '0;
         DOUT      <= 1'b0;
         DOUT_T    <= 1'b1;
         rdatac    <= 1'b1;
         held      <= '0;
         DRDY      <= 1'b1;
         hi_cnt    <= '0;
         // NOTE: the register file has architectural reset values, so it is cleared like any flop.
         regs      <= '{default: 8'h00};
      end else begin
         s_axis_tready <= 1'b1;
         DOUT_T        <= ss_s;
         if (ss_s) begin
            bit_cnt   <= '0;
            DOUT      <= 1'b0;
            frame_err <= (bit_cnt != 3'd0);
            if (rd_cnt != 5'd24) begin
               rd_cnt    <= '0;
               out_shift <= '0;
            end
         end else begin
            if (sck_rise) begin
               DOUT      <= out_shift[23];
               out_shift <= {out_shift[22:0], 1'b0};
            end
            if (sck_fall) begin
               bit_cnt <= bit_cnt + 3'd1;
               in_sr   <= rx_byte[6:0];
               if (rd_cnt != 5'd0) rd_cnt <= rd_cnt - 5'd1;
            end
            if (load_rd) out_shift <= {rd_byte, 16'h0000};
         end

         if (cmd_rst) begin
            regs   <= '{default: 8'h00};
            rdatac <= 1'b1;
         end
         if (set_rdatac) rdatac <= 1'b1;
         if (clr_rdatac) rdatac <= 1'b0;
         if (wr_ok) regs[ptr] <= rx_byte;

         if (sample_acc) held <= s_axis_tdata[23:0];
         DRDY   <= drdy_nxt;
         hi_cnt <= hi_nxt;
         if (drdy_fall && rdatac && !rd_busy) begin
            out_shift <= sample_acc ? s_axis_tdata[23:0] : held;
            rd_cnt    <= 5'd24;
         end
         if (load_data) begin
            out_shift <= held;
            rd_cnt    <= 5'd24;
         end
      end
   end

endmodule
